// File: rtl/cycle_control.sv
// Timing-and-control sequencer for the basic-computer sequence counter: decodes t and issues fetch/decode/execute strobes.
// Optional lock-step checking of the counter against an internal copy is enabled by defining CYCLE_CTRL_SYNC_CHECK_EN.
module cycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] t,
    input  logic [2:0] ir_op,
    input  logic       mem_ready,
    output logic       hold,
    output logic       sc_rst,
    output logic [3:0] tsig,
    output logic       ar_ld,
    output logic       mem_rd,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       alu_en,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [2:0] OP_HLT       = 3'b111;
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;
    logic       t_mismatch;

`ifdef CYCLE_CTRL_SYNC_CHECK_EN
    logic [1:0] exp_t_q, exp_t_d;
    assign t_mismatch = (t != exp_t_q);
`else
    assign t_mismatch = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
`ifdef CYCLE_CTRL_SYNC_CHECK_EN
            exp_t_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
`ifdef CYCLE_CTRL_SYNC_CHECK_EN
            exp_t_q <= exp_t_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = wait_q;
        err_d   = err_q;
`ifdef CYCLE_CTRL_SYNC_CHECK_EN
        exp_t_d = exp_t_q;
`endif
        hold    = 1'b0;
        sc_rst  = 1'b0;
        tsig    = 4'b0000;
        ar_ld   = 1'b0;
        mem_rd  = 1'b0;
        ir_ld   = 1'b0;
        pc_inc  = 1'b0;
        alu_en  = 1'b0;
        busy    = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                // Counter is held at 0 here, so the first RUN cycle always sees t=0.
                sc_rst = 1'b1;
                if (start) begin
                    state_d = S_RUN;
                    err_d   = 1'b0;
                    wait_d  = 8'd0;
`ifdef CYCLE_CTRL_SYNC_CHECK_EN
                    exp_t_d = 2'd0;
`endif
                end
            end
            S_RUN: begin
                busy = 1'b1;
                tsig = 4'b0001 << t;
                if (t_mismatch) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    case (t)
                        2'd0: ar_ld = 1'b1;
                        2'd1: begin
                            mem_rd = 1'b1;
                            if (mem_ready) begin
                                ir_ld  = 1'b1;
                                pc_inc = 1'b1;
                                op_d   = ir_op;
                                wait_d = 8'd0;
                            end else begin
                                hold   = 1'b1;
                                wait_d = wait_q + 8'd1;
                                if (wait_q == TIMEOUT_LAST) begin
                                    err_d   = 1'b1;
                                    state_d = S_HALT;
                                end
                            end
                        end
                        2'd2: ;
                        default: begin
                            if (op_q != OP_HLT) alu_en  = 1'b1;
                            else                state_d = S_HALT;
                        end
                    endcase
                end
`ifdef CYCLE_CTRL_SYNC_CHECK_EN
                if (!hold) exp_t_d = exp_t_q + 2'd1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_cycle_control.sv
// Bench for cycle_control: a behavioural sequence counter closes the hold/sc_rst loop; directed cycles push
// hand-computed expected outputs into a queue that a negedge monitor pops and compares.
module tb_cycle_control;

    localparam int W = 15;
    localparam logic [4:0] SB_NONE  = 5'b00000;
    localparam logic [4:0] SB_AR    = 5'b10000;
    localparam logic [4:0] SB_FETCH = 5'b01110;
    localparam logic [4:0] SB_WAIT  = 5'b01000;
    localparam logic [4:0] SB_ALU   = 5'b00001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] t;
    logic [2:0] ir_op = 3'b001;
    logic       mem_ready = 1'b1;
    logic       hold, sc_rst;
    logic [3:0] tsig;
    logic       ar_ld, mem_rd, ir_ld, pc_inc, alu_en, busy, err;

    logic [1:0] sc_cnt = 2'd0;
    logic       force_en = 1'b0;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    cycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .t(t), .ir_op(ir_op), .mem_ready(mem_ready),
        .hold(hold), .sc_rst(sc_rst), .tsig(tsig), .ar_ld(ar_ld), .mem_rd(mem_rd),
        .ir_ld(ir_ld), .pc_inc(pc_inc), .alu_en(alu_en), .busy(busy), .err(err)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // 2-bit sequence counter with clear and freeze, plus an override to fake a slipped count
    always @(posedge clk) begin
        if (sc_rst)     sc_cnt <= 2'd0;
        else if (!hold) sc_cnt <= sc_cnt + 2'd1;
    end
    assign t = force_en ? 2'd3 : sc_cnt;

    function automatic logic [W-1:0] ev(input logic [1:0] tv, input logic h, input logic sr,
                                        input logic [4:0] stb, input logic b, input logic e);
        logic [3:0] ts;
        ts = b ? (4'b0001 << tv) : 4'b0000;
        return {tv, h, sr, ts, stb, b, e};
    endfunction

    // driver: apply one cycle of inputs just after the edge and queue the expected outputs for it
    task automatic cyc(input logic r, input logic s, input logic [2:0] op, input logic mr,
                       input logic fe, input logic [W-1:0] e, input string name);
        @(posedge clk);
        #1;
        rst       = r;
        start     = s;
        ir_op     = op;
        mem_ready = mr;
        force_en  = fe;
        exp_q.push_back(e);
        tag_q.push_back(name);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] got, want;
        string        name;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            name = tag_q.pop_front();
            got  = {t, hold, sc_rst, tsig, ar_ld, mem_rd, ir_ld, pc_inc, alu_en, busy, err};
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL %s: got %b expected %b (t,hold,sc_rst,tsig,ar,rd,ir,inc,alu,busy,err)",
                         name, got, want);
            end
        end
    end

    initial begin
        // reset state and idle
        cyc(0, 0, 3'b001, 1, 0, ev(0, 0, 1, SB_NONE, 0, 0), "reset0");
        cyc(0, 0, 3'b001, 1, 0, ev(0, 0, 1, SB_NONE, 0, 0), "reset1");
        cyc(1, 1, 3'b001, 1, 0, ev(0, 0, 1, SB_NONE, 0, 0), "idle_start");
        // two plain instructions
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 0, SB_AR,    1, 0), "plain_t0");
            cyc(1, 0, 3'b001, 1, 0, ev(1, 0, 0, SB_FETCH, 1, 0), "plain_t1");
            cyc(1, 0, 3'b001, 1, 0, ev(2, 0, 0, SB_NONE,  1, 0), "plain_t2");
            cyc(1, 0, 3'b001, 1, 0, ev(3, 0, 0, SB_ALU,   1, 0), "plain_t3");
        end
        // three memory wait cycles stretch the instruction to 7 cycles
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 0, SB_AR, 1, 0), "wait_t0");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 3'b001, 0, 0, ev(1, 1, 0, SB_WAIT, 1, 0), "wait_hold");
        cyc(1, 0, 3'b001, 1, 0, ev(1, 0, 0, SB_FETCH, 1, 0), "wait_fetch");
        cyc(1, 0, 3'b001, 1, 0, ev(2, 0, 0, SB_NONE,  1, 0), "wait_t2");
        cyc(1, 0, 3'b001, 1, 0, ev(3, 0, 0, SB_ALU,   1, 0), "wait_t3");
        // HLT; start during the HLT t=3 cycle must be ignored
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 0, SB_AR,    1, 0), "hlt_t0");
        cyc(1, 0, 3'b111, 1, 0, ev(1, 0, 0, SB_FETCH, 1, 0), "hlt_t1");
        cyc(1, 0, 3'b001, 1, 0, ev(2, 0, 0, SB_NONE,  1, 0), "hlt_t2");
        cyc(1, 1, 3'b001, 1, 0, ev(3, 0, 0, SB_NONE,  1, 0), "hlt_t3");
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 1, SB_NONE,  0, 0), "halt_ign_start");
        cyc(1, 1, 3'b001, 1, 0, ev(0, 0, 1, SB_NONE,  0, 0), "halt_start");
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 0, SB_AR,    1, 0), "resume_t0");
        cyc(1, 0, 3'b001, 1, 0, ev(1, 0, 0, SB_FETCH, 1, 0), "resume_t1");
        cyc(1, 0, 3'b001, 1, 0, ev(2, 0, 0, SB_NONE,  1, 0), "resume_t2");
        cyc(1, 0, 3'b001, 1, 0, ev(3, 0, 0, SB_ALU,   1, 0), "resume_t3");
        // memory timeout after 4 hold cycles; start clears err
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 0, SB_AR, 1, 0), "to_t0");
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 3'b001, 0, 0, ev(1, 1, 0, SB_WAIT, 1, 0), "to_hold");
        cyc(1, 0, 3'b001, 0, 0, ev(1, 0, 1, SB_NONE,  0, 1), "to_halt");
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 1, SB_NONE,  0, 1), "to_halt2");
        cyc(1, 1, 3'b001, 1, 0, ev(0, 0, 1, SB_NONE,  0, 1), "to_start");
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 0, SB_AR,    1, 0), "to_clr_t0");
        cyc(1, 0, 3'b001, 1, 0, ev(1, 0, 0, SB_FETCH, 1, 0), "to_clr_t1");
        cyc(1, 0, 3'b001, 1, 0, ev(2, 0, 0, SB_NONE,  1, 0), "to_clr_t2");
        cyc(1, 0, 3'b001, 1, 0, ev(3, 0, 0, SB_ALU,   1, 0), "to_clr_t3");
        // counter slips to 3 where 1 is expected
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 0, SB_AR, 1, 0), "sync_t0");
`ifdef CYCLE_CTRL_SYNC_CHECK_EN
        cyc(1, 0, 3'b001, 1, 1, ev(3, 0, 0, SB_NONE, 1, 0), "sync_force");
        cyc(1, 0, 3'b001, 1, 0, ev(2, 0, 1, SB_NONE, 0, 1), "sync_halt");
        cyc(1, 1, 3'b001, 1, 0, ev(0, 0, 1, SB_NONE, 0, 1), "sync_start");
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 0, SB_AR,   1, 0), "sync_rec_t0");
`else
        cyc(1, 0, 3'b001, 1, 1, ev(3, 0, 0, SB_ALU,  1, 0), "sync_force");
        cyc(1, 0, 3'b001, 1, 0, ev(2, 0, 0, SB_NONE, 1, 0), "sync_t2");
        cyc(1, 0, 3'b001, 1, 0, ev(3, 0, 0, SB_ALU,  1, 0), "sync_t3");
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 0, SB_AR,   1, 0), "sync_rec_t0");
`endif
        // asynchronous reset mid-instruction at t=2
        cyc(1, 0, 3'b001, 1, 0, ev(1, 0, 0, SB_FETCH, 1, 0), "rm_t1");
        cyc(0, 0, 3'b001, 1, 0, ev(2, 0, 1, SB_NONE,  0, 0), "rm_async");
        cyc(0, 0, 3'b001, 1, 0, ev(0, 0, 1, SB_NONE,  0, 0), "rm_held");
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 1, SB_NONE,  0, 0), "rm_idle0");
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 1, SB_NONE,  0, 0), "rm_idle1");
        cyc(1, 1, 3'b001, 1, 0, ev(0, 0, 1, SB_NONE,  0, 0), "rm_start");
        cyc(1, 0, 3'b001, 1, 0, ev(0, 0, 0, SB_AR,    1, 0), "rm_t0");
        cyc(1, 0, 3'b001, 1, 0, ev(1, 0, 0, SB_FETCH, 1, 0), "rm_t1b");

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
